// File: rtl/spi_mem_sequencer.sv
// SPI-slave memory sequencer: decodes cmd/addr frames into word writes (8/80/128-bit) and gap-free streamed reads.
// Latency: mem_we/mem_re/err are registered one edge after the sampling edge; miso carries the MSB one edge after mem_re.
// Backpressure: none, the SPI master paces everything; cs_n high at any edge aborts the frame without a strobe.
module spi_mem_sequencer #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 128
) (
    input  logic              spi_clk_data,
    input  logic              rst_n,
    input  logic              cs_n,
    input  logic              mosi,
    output logic              miso,
    output logic [1:0]        mem_sel,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    output logic              mem_re,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              err
);
    localparam int MAX_W = (DATA_W > ADDR_W) ? DATA_W : ADDR_W;
    localparam int CNT_W = $clog2(MAX_W) + 1;

    typedef enum logic [2:0] {IDLE, CMD, ADDR, WDATA, RDATA, DISCARD} state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic              is_read_q, is_read_d;
    logic              miso_q, miso_d;
    logic [1:0]        sel_q, sel_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              we_q, we_d;
    logic              re_q, re_d;
    logic              err_q, err_d;

    logic [DATA_W-1:0] shift_in;
    logic [CNT_W-1:0]  wlen_m1;
    logic [DATA_W-1:0] word_mask;
    logic              rd_msb;
    logic              sh_next;
    logic              cmd_ok;

    assign shift_in = {shift_q[DATA_W-2:0], mosi};
    assign cmd_ok   = ((shift_in[7:4] == 4'b0001) || (shift_in[7:4] == 4'b0010)) && (shift_in[1:0] != 2'b11);

    // Word geometry of the selected memory: last bit index, lane mask, and the bits miso needs next.
    always_comb begin
        case (sel_q)
            2'd0:    wlen_m1 = CNT_W'(7);
            2'd1:    wlen_m1 = CNT_W'(79);
            default: wlen_m1 = CNT_W'(127);
        endcase
        word_mask = '0;
        rd_msb    = 1'b0;
        sh_next   = 1'b0;
        for (int i = 0; i < DATA_W; i++) begin
            word_mask[i] = (i <= int'(wlen_m1));
            if (i == int'(wlen_m1)) rd_msb = mem_rdata[i];
            if (i + 1 == int'(wlen_m1)) sh_next = shift_q[i];
        end
    end

    // Next-state and output decode; strobes and miso default low every edge.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        shift_d   = shift_q;
        is_read_d = is_read_q;
        sel_d     = sel_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        we_d      = 1'b0;
        re_d      = 1'b0;
        miso_d    = 1'b0;
        err_d     = 1'b0;
        if (cs_n) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    shift_d = shift_in;
                    cnt_d   = CNT_W'(1);
                    state_d = CMD;
                end
                CMD: begin
                    shift_d = shift_in;
                    if (cnt_q == CNT_W'(7)) begin
                        cnt_d = '0;
                        if (cmd_ok) begin
                            sel_d     = shift_in[1:0];
                            is_read_d = shift_in[5];
                            state_d   = ADDR;
                        end else begin
                            err_d   = 1'b1;
                            state_d = DISCARD;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                ADDR: begin
                    shift_d = shift_in;
                    if (cnt_q == CNT_W'(ADDR_W - 1)) begin
                        cnt_d  = '0;
                        addr_d = shift_in[ADDR_W-1:0];
                        if (is_read_q) begin
                            re_d    = 1'b1;
                            state_d = RDATA;
                        end else begin
                            state_d = WDATA;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                WDATA: begin
                    shift_d = shift_in;
                    // Address advances only once the previous write strobe has been seen.
                    if (we_q) addr_d = addr_q + 1'b1;
                    if (cnt_q == wlen_m1) begin
                        cnt_d   = '0;
                        wdata_d = shift_in & word_mask;
                        we_d    = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                RDATA: begin
                    if (re_q) begin
                        // Read data arrives the edge after mem_re: load and present the MSB at once.
                        shift_d = mem_rdata & word_mask;
                        miso_d  = rd_msb;
                        cnt_d   = CNT_W'(1);
                    end else begin
                        shift_d = shift_q << 1;
                        miso_d  = sh_next;
                        if (cnt_q == wlen_m1) begin
                            // Driving bit 0: fetch the next word now so the stream has no gap.
                            cnt_d  = '0;
                            addr_d = addr_q + 1'b1;
                            re_d   = 1'b1;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
                DISCARD: begin
                    state_d = DISCARD;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // State, datapath and output registers, cleared asynchronously.
    always_ff @(posedge spi_clk_data or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            shift_q   <= '0;
            is_read_q <= 1'b0;
            miso_q    <= 1'b0;
            sel_q     <= 2'd0;
            addr_q    <= '0;
            wdata_q   <= '0;
            we_q      <= 1'b0;
            re_q      <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            shift_q   <= shift_d;
            is_read_q <= is_read_d;
            miso_q    <= miso_d;
            sel_q     <= sel_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            we_q      <= we_d;
            re_q      <= re_d;
            err_q     <= err_d;
        end
    end

    assign miso      = miso_q;
    assign mem_sel   = sel_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign mem_we    = we_q;
    assign mem_re    = re_q;
    assign err       = err_q;
    assign busy      = (state_q != IDLE);

endmodule
